// File: rtl/seq_pkg.sv
// Shared definitions for the serial-stream front end of the sequence detector.
//   ser_state_e : serializer FSM states
//   SER_DATA_W  : default word width
//   SER_DEPTH   : default FIFO depth
//   lvl_w()     : width of a FIFO occupancy count for a given depth
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_DATA_W = 8;
  localparam int SER_DEPTH  = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SER_LEVEL_W = lvl_w(SER_DEPTH);

endpackage

// File: rtl/seq_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write wdata_i (caller guarantees !full_o)
//   pop_i      : drop the head (caller guarantees level_o != 0)
//   rdata_o    : current head word
//   level_o    : occupancy 0..DEPTH
//   full_o     : level_o == DEPTH
module seq_sync_fifo
  import seq_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W,
  parameter int DEPTH  = SER_DEPTH,
  localparam int LW    = lvl_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [LW-1:0]     level_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the sequence detector's serial input.
//   clk, rst_n         : clock, synchronous active-low reset
//   s_valid/s_ready    : upstream word handshake, s_data is the word
//   bit_en             : downstream consumes the current bit this cycle
//   bit_out/bit_valid  : serial bit and its qualifier
//   bit_last           : current bit is the last of its word
//   level              : FIFO occupancy, not counting the word being shifted
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int DATA_W    = SER_DATA_W,
  parameter int DEPTH     = SER_DEPTH,
  parameter int MSB_FIRST = 1,
  localparam int LW       = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              bit_en,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_last,
  output logic [LW-1:0]     level
);

  localparam int CW = $clog2(DATA_W);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              full, push, pop, fifo_nempty;
  logic [DATA_W-1:0] head;

  // rst_n gating keeps upstream from seeing ready while reset is held.
  assign s_ready     = rst_n & ~full;
  assign push        = s_valid & s_ready;
  assign fifo_nempty = (level != '0);

  seq_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (s_data),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          sreg_d  = head;
          cnt_d   = CW'(DATA_W - 1);
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (bit_en) begin
          if (cnt_q != '0) begin
            sreg_d = (MSB_FIRST != 0) ? {sreg_q[DATA_W-2:0], 1'b0}
                                      : {1'b0, sreg_q[DATA_W-1:1]};
            cnt_d  = cnt_q - 1'b1;
          end else if (fifo_nempty) begin
            // Reload on the last bit so consecutive words abut.
            pop    = 1'b1;
            sreg_d = head;
            cnt_d  = CW'(DATA_W - 1);
          end else begin
            state_d = SER_IDLE;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // Shifter contents may be stale in IDLE, so every output is qualified.
  assign bit_valid = (state_q == SER_SHIFT);
  assign bit_out   = bit_valid & ((MSB_FIRST != 0) ? sreg_q[DATA_W-1] : sreg_q[0]);
  assign bit_last  = bit_valid & (cnt_q == '0);

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n, s_valid, s_ready, bit_en, bit_out, bit_valid, bit_last;
  logic [7:0] s_data;
  logic [2:0] level;
  logic       l_sv, l_rdy, l_be, l_bo, l_bv, l_bl;
  logic [7:0] l_sd;
  logic [2:0] l_lvl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bit_en(bit_en), .bit_out(bit_out), .bit_valid(bit_valid), .bit_last(bit_last),
    .level(level));

  seq_bit_serializer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_valid(l_sv), .s_ready(l_rdy), .s_data(l_sd),
    .bit_en(l_be), .bit_out(l_bo), .bit_valid(l_bv), .bit_last(l_bl),
    .level(l_lvl));

  // Reference: a queue of buffered words and a queue of bits still owed
  // from the word currently on the wire.
  logic [7:0] m_fifo[$];
  bit         m_bits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc, ld;
    logic [7:0] w;
    if (!rst_n) begin
      m_fifo.delete();
      m_bits.delete();
    end else begin
      acc = s_valid && (m_fifo.size() < 4);
      ld  = ((m_bits.size() == 0) || (bit_en && m_bits.size() == 1)) && (m_fifo.size() != 0);
      if (bit_en && m_bits.size() > 0) void'(m_bits.pop_front());
      if (ld) begin
        w = m_fifo.pop_front();
        for (int i = 7; i >= 0; i--) m_bits.push_back(w[i]);
      end
      if (acc) m_fifo.push_back(s_data);
    end
  endtask

  task automatic check_model();
    chk("m_bit_valid", 32'(bit_valid), 32'(m_bits.size() != 0));
    chk("m_bit_out",   32'(bit_out),   32'((m_bits.size() != 0) ? m_bits[0] : 1'b0));
    chk("m_bit_last",  32'(bit_last),  32'(m_bits.size() == 1));
    chk("m_level",     32'(level),     32'(m_fifo.size()));
    chk("m_s_ready",   32'(s_ready),   32'(rst_n && (m_fifo.size() < 4)));
  endtask

  // Called just after a falling edge: drive, cross one rising edge, check.
  task automatic cyc(input logic sv, input logic [7:0] sd, input logic be, input logic rn);
    s_valid = sv; s_data = sd; bit_en = be; rst_n = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic sv; logic [7:0] sd; logic be;
    logic bv; logic bo; logic bl; logic rdy; logic [2:0] lvl;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [7:0]  pb;
    logic [15:0] got16;
    logic [31:0] lastmask;
    logic [7:0]  gotb;
    int nv, first, lastc, acc_cnt, hold_err;
    logic prev_bo, prev_bl;
    logic [7:0] words[6];
    logic [11:0] pat;

    s_valid = 0; s_data = 0; bit_en = 0; rst_n = 0;
    l_sv = 0; l_sd = 0; l_be = 0;

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_s_ready_low", 32'(s_ready), 0);
    chk("rst_bit_valid",   32'(bit_valid), 0);
    chk("rst_level",       32'(level), 0);
    cyc(0, 0, 0, 1);

    // --- table: single word 8'hB3, bit_en held high ---
    pb = 8'hB3;
    tbl[0] = '{1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b1, pb[8-i], (i == 8), 1'b1, 3'd0};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].sv, tbl[i].sd, tbl[i].be, 1);
      chk($sformatf("tbl%0d_bit_valid", i), 32'(bit_valid), 32'(tbl[i].bv));
      chk($sformatf("tbl%0d_bit_out", i),   32'(bit_out),   32'(tbl[i].bo));
      chk($sformatf("tbl%0d_bit_last", i),  32'(bit_last),  32'(tbl[i].bl));
      chk($sformatf("tbl%0d_s_ready", i),   32'(s_ready),   32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_level", i),     32'(level),     32'(tbl[i].lvl));
    end

    // --- back-to-back 8'h70, 8'hC0 ---
    got16 = '0; lastmask = '0; nv = 0; first = -1; lastc = -1;
    cyc(1, 8'h70, 1, 1);
    cyc(1, 8'hC0, 1, 1);
    for (int c = 0; c < 20; c++) begin
      if (bit_valid) begin
        got16 = {got16[14:0], bit_out};
        if (bit_last) lastmask |= (32'd1 << nv);
        if (first < 0) first = c;
        lastc = c;
        nv++;
      end
      cyc(0, 0, 1, 1);
    end
    chk("b2b_valid_count", nv, 16);
    chk("b2b_no_gap", lastc - first + 1, 16);
    chk("b2b_bits", 32'(got16), 32'(16'b0111000011000000));
    chk("b2b_last_pos", lastmask, (32'd1 << 7) | (32'd1 << 15));

    // --- fill with bit_en low ---
    words = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("full_s_ready_6th", 32'(s_ready), 0);
      if (s_ready) acc_cnt++;
      cyc(1, words[i], 0, 1);
    end
    chk("full_accepted", acc_cnt, 5);
    chk("full_level", 32'(level), 4);
    chk("full_bit0", 32'(bit_out), 1);
    cyc(0, 0, 1, 1);
    chk("full_shifted", 32'(bit_out), 0);
    chk("full_level_hold", 32'(level), 4);
    for (int c = 0; c < 45; c++) cyc(0, 0, 1, 1);
    chk("full_drained", 32'(bit_valid), 0);

    // --- bit_en toggling mid-word on 8'hA5 ---
    cyc(1, 8'hA5, 1, 1);
    cyc(0, 0, 1, 1);
    pat = 12'b1111_1111_0011;  // applied LSB first: 1,1,0,0,1,...
    gotb = '0; nv = 0; hold_err = 0;
    for (int i = 0; i < 12; i++) begin
      if (bit_valid && pat[i]) begin
        gotb = {gotb[6:0], bit_out};
        nv++;
      end
      prev_bo = bit_out; prev_bl = bit_last;
      cyc(0, 0, pat[i], 1);
      if (!pat[i] && (bit_out !== prev_bo || bit_last !== prev_bl)) hold_err++;
    end
    chk("toggle_hold", hold_err, 0);
    chk("toggle_count", nv, 8);
    chk("toggle_bits", 32'(gotb), 32'h A5);

    // --- reset mid-word with two words queued ---
    cyc(1, 8'hFF, 1, 1);
    cyc(1, 8'h11, 1, 1);
    cyc(1, 8'h22, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("rstmid_prior_valid", 32'(bit_valid), 1);
    chk("rstmid_prior_level", 32'(level), 2);
    cyc(0, 0, 1, 0);
    chk("rstmid_bit_valid", 32'(bit_valid), 0);
    chk("rstmid_level", 32'(level), 0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 1, 1);
      if (bit_valid) nv++;
    end
    chk("rstmid_no_residual", nv, 0);

    // --- LSB-first instance: 8'h01 ---
    l_sv = 1; l_sd = 8'h01; l_be = 1;
    cyc(0, 0, 0, 1);
    l_sv = 0;
    gotb = '0; nv = 0;
    for (int c = 0; c < 11; c++) begin
      cyc(0, 0, 0, 1);
      if (l_bv) begin
        if (nv < 8) gotb[nv] = l_bo;
        nv++;
      end
    end
    chk("lsb_count", nv, 8);
    chk("lsb_bits", 32'(gotb), 32'h01);

    // --- randomized against the reference ---
    for (int c = 0; c < 3000; c++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 199) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Upstream feeder for the sequence detector: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO and emits them one bit per enabled cycle as a serial stream (`bit_out`/`bit_valid`) that drives the detector's serial `in` input. Consecutive words stream back-to-back with no bubble, so multi-word bit patterns reach the detector exactly as sent. Flow control runs through `s_ready` upstream and `bit_en` downstream.

## Interface
- `DATA_W`, 8: word width in bits; ≥2.
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `MSB_FIRST`, 1: 1 = shift out MSB first, 0 = LSB first.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  FIFO can accept a word.
- `s_data`  in  DATA_W  upstream word.
- `bit_en`  in  1  downstream consumes the current bit this cycle.
- `bit_out`  out  1  current serial bit.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_last`  out  1  current bit is the final bit of its word.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the word in the shifter.

## Operation
- Push when `s_valid && s_ready`. `s_ready = rst_n && (level != DEPTH)`.
- A push into a full FIFO is never accepted, even if a pop happens the same cycle.
- Pop occurs only on an internal load. `level` is +1 on push only, −1 on pop only, and unchanged on both.
- FSM states: IDLE and SHIFT.
- IDLE:
  - If `level != 0`, pop the FIFO head into the shift register, set the bit counter to `DATA_W-1` and go to SHIFT.
  - Otherwise stay in IDLE.
  - Loading does not require `bit_en`.
- SHIFT:
  - `bit_valid = 1`.
  - `bit_out` = shift register MSB if `MSB_FIRST`, else LSB.
  - `bit_last = (counter == 0)`.
  - On `bit_en` with counter > 0: shift one position toward the output end and decrement the counter.
  - On `bit_en` with counter == 0: if `level != 0`, pop and reload in the same cycle and stay in SHIFT (no gap); else go to IDLE.
  - With `bit_en` = 0: all shifter state holds, and `bit_out`/`bit_last` stay stable.
- In IDLE, `bit_out`, `bit_valid` and `bit_last` are all 0.
- FIFO pointers wrap modulo `DEPTH`. Occupancy comes from `level`, not from pointer compare.

## Timing
- Reset (rst_n low at an edge):
  - Pointers and `level` go to 0, FSM to IDLE, shift register and counter to 0.
  - `bit_valid`, `bit_out` and `bit_last` are 0 from the next cycle. `s_ready` is 0 while `rst_n` is low.
- Reset mid-word: the partial word and all FIFO contents are discarded, and no further bits are emitted.
- Latency: a word accepted at edge k into an empty FIFO with IDLE FSM is loaded at edge k+1. Its first bit is valid in the cycle after k+1, i.e. 2 cycles after the handshake.
- Throughput: 1 bit per cycle with `bit_en` held high. A word takes `DATA_W` cycles, and successive words have zero idle cycles while the FIFO is non-empty.
- Total buffering is `DEPTH+1` words: `DEPTH` in the FIFO plus 1 in the shifter.
- All outputs are driven from registers, plus the `rst_n` gating on `s_ready`. There is no combinational path from `s_valid` or `bit_en` to any output.

## Structure
- Shared package `seq_pkg`:
  - state enum typedef (`SER_IDLE`, `SER_SHIFT`);
  - default `DATA_W`;
  - helper constant for the `level` width.
- Sub-module `seq_sync_fifo` (parameters `DATA_W`, `DEPTH`):
  - ports push, pop, data in/out, level and full;
  - read data is the current head (first-word fall-through).
- The top level holds the FSM, shift register, bit counter and output logic.

## Test plan
- Idle, push 8'hB3 with `bit_en`=1:
  - `bit_valid` rises 2 cycles after the handshake;
  - bits 1,0,1,1,0,0,1,1;
  - `bit_last` only on the 8th bit;
  - `bit_valid` low the next cycle.
- Push 8'h70 then 8'hC0 back-to-back:
  - 16 consecutive `bit_valid` cycles, bits 0111000011000000;
  - `bit_last` on bits 8 and 16.
- Hold `bit_en`=0 and push 6 words:
  - 5 words accepted (1 loaded, `level`=4) and `s_ready`=0 on the 6th;
  - after one `bit_en` pulse, `bit_out` shifts and `level` stays 4.
- Toggle `bit_en` 1,0,0,1 mid-word on 8'hA5:
  - `bit_out` and `bit_last` hold during the 0 cycles;
  - the full sequence 10100101 is still delivered.
- Assert `rst_n`=0 for 1 cycle after bit 3 of 8'hFF with 2 words queued:
  - `bit_valid`=0 and `level`=0 on the next cycle;
  - no residual bits.
- Run with `MSB_FIRST`=0 and push 8'h01: bits 1,0,0,0,0,0,0,0.
